div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle sequential divider for DIV/DIVU in the EX stage.
- Produces the {remainder, quotient} pair that EX/MEM forwards into the HI/LO register unit, which MFHI/MFLO/MTHI/MTLO read and write.
- Holds its result until EX releases it, so the pipeline stall controller can freeze earlier stages during the operation.

Parameters:
- DATA_W, 32, operand width; result_o is 2*DATA_W. The iteration count equals DATA_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request from EX. Held high until ready_o has been seen.
- annul_i  input  1  abort the current operation (exception or flush).
- result_o  output  2*DATA_W  [2W-1:W] = remainder (to HI), [W-1:0] = quotient (to LO).
- ready_o  output  1  result_o is valid.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, result_o=0, ready_o=0, counter=0. Reset takes priority in every state, including mid-division.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 at edge E0: capture the operands and the signed flag.
  - Divisor==0: go to BYZERO.
  - Otherwise: go to ON with counter=0.
  - Operands sampled at E0 are the only ones used; later input changes are ignored.
  - start_i with annul_i=1 is ignored.
  - ready_o=0 and result_o=0 throughout IDLE.
- Signed preprocessing at E0: each operand with MSB=1 and signed_div_i=1 is replaced by its two's-complement magnitude. -2^31 maps to 0x80000000 as an unsigned value.
- ON:
  - One restoring shift-subtract iteration per edge, using a 2W+1-bit working register {rem, quot}.
  - Each step: shift left 1; trial = rem − divisor; if trial ≥ 0, rem=trial and quotient LSB=1, else quotient LSB=0.
  - Edges E1..E32 perform the 32 iterations.
  - Edge E33 (counter==DATA_W) applies the sign fix, registers result_o, sets ready_o=1 and enters END.
  - Total: ready_o is first high after E33.
- Sign fix (signed only):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Unsigned results pass through unchanged.
- BYZERO: the next edge (E1) sets result_o=0, ready_o=1 and enters END.
- END:
  - result_o and ready_o hold while start_i=1.
  - The first edge with start_i=0 returns to IDLE, ready_o=0, result_o=0.
  - A new start therefore requires at least one cycle of start_i low.
  - annul_i in END has no effect; EX already owns the result.
- Annul: annul_i=1 at any edge in ON or BYZERO returns to IDLE. No ready_o pulse and no partial result are exposed.
- Overflow: signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. This is defined, not trapped.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Unsigned 100/7 (signed_div_i=0), start held → ready_o rises after E33; result_o = HI 0x00000002, LO 0x0000000E; ready_o=0 before E33.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → LO 0xFFFFFFFD, HI 0xFFFFFFFF. Signed 7/−2 → LO 0xFFFFFFFD, HI 0x00000001.
- Divide by zero: 0x00000005 / 0 → ready_o after E1, result_o = 0. Drop start_i → next edge: ready_o=0, state IDLE.
- Annul then recover:
  - Start 1000/3, assert annul_i at E10 → IDLE; ready_o stays 0 for 40 cycles.
  - Then unsigned 0xFFFFFFFF / 0x00000001 → LO 0xFFFFFFFF, HI 0 at E33.
- Overflow and hold: signed 0x80000000 / 0xFFFFFFFF → LO 0x80000000, HI 0.
  - Keep start_i high 5 extra cycles → outputs unchanged.
  - Change opdata1_i mid-operation → result unaffected.
- Reset mid-op: rst=1 at E15 of a division → result_o=0 and ready_o=0 on that edge.
  - A fresh start after rst deasserts completes normally: 9/3 → LO 3, HI 0.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The master side issues DIV/DIVU requests; the slave side returns {remainder, quotient}.
interface div_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU: DATA_W iterations plus one sign-fix edge.
// Result {remainder, quotient} is held until EX drops start_i.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t                state, state_nxt;
  logic [2*DATA_W:0]     work, work_nxt;
  logic [DATA_W-1:0]     divisor, divisor_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  neg_q, neg_q_nxt;
  logic                  neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0]   result, result_nxt;
  logic                  ready, ready_nxt;

  logic [2*DATA_W:0]     shifted;
  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     a_mag, b_mag, q_raw, r_raw;
  logic                  a_neg, b_neg, accept;

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

  assign accept = bus.start_i && !bus.annul_i;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
      S_BYZERO: state_nxt = bus.annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (bus.annul_i)                   state_nxt = S_IDLE;
        else if (cnt == CNT_W'(DATA_W))    state_nxt = S_END;
      end
      S_END:    if (!bus.start_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    work_nxt    = work;
    divisor_nxt = divisor;
    cnt_nxt     = cnt;
    neg_q_nxt   = neg_q;
    neg_r_nxt   = neg_r;
    result_nxt  = result;
    ready_nxt   = ready;

    a_neg   = bus.signed_div_i && bus.opdata1_i[DATA_W-1];
    b_neg   = bus.signed_div_i && bus.opdata2_i[DATA_W-1];
    a_mag   = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    b_mag   = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    shifted = work << 1;
    // Borrow out of the (DATA_W+1)-bit subtract means the trial remainder went negative.
    trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};
    q_raw   = work[DATA_W-1:0];
    r_raw   = work[2*DATA_W-1:DATA_W];

    unique case (state)
      S_IDLE: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
        if (accept) begin
          work_nxt    = {{(DATA_W+1){1'b0}}, a_mag};
          divisor_nxt = b_mag;
          cnt_nxt     = '0;
          neg_q_nxt   = a_neg ^ b_neg;
          neg_r_nxt   = a_neg;
        end
      end
      S_BYZERO: begin
        if (!bus.annul_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b1;
        end
      end
      S_ON: begin
        if (bus.annul_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end else if (cnt == CNT_W'(DATA_W)) begin
          result_nxt = {neg_r ? -r_raw : r_raw, neg_q ? -q_raw : q_raw};
          ready_nxt  = 1'b1;
        end else begin
          work_nxt = trial[DATA_W] ? shifted
                                   : {trial, shifted[DATA_W-1:1], 1'b1};
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      end
      default: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      divisor <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      work    <= work_nxt;
      divisor <= divisor_nxt;
      cnt     <= cnt_nxt;
      neg_q   <= neg_q_nxt;
      neg_r   <= neg_r_nxt;
      result  <= result_nxt;
      ready   <= ready_nxt;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected {rem, quot}, monitor checks on each ready rise.
module tb_div_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_q[$];

  div_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division at 64-bit width, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest queued expectation.
  initial begin
    logic prev_ready;
    logic [63:0] e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready_o && !prev_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got result 0x%0h with no pending request", bus.result_o);
        end else begin
          e = exp_q.pop_front();
          check("result", bus.result_o, e);
        end
      end
      prev_ready = bus.ready_o;
    end
  end

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e, input int hold, input bit mutate);
    int lat;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    exp_q.push_back(e);
    lat = -1;
    for (int n = 0; n <= 60; n++) begin
      @(negedge clk);
      if (mutate && n == 5) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      if (bus.ready_o) begin
        lat = n;
        break;
      end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", 64'(bus.ready_o), 64'd1);
      check("hold_result", bus.result_o, e);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check("release_ready", 64'(bus.ready_o), 64'd0);
    check("release_result", bus.result_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ready_seen;
    logic        sgn;
    logic [31:0] a, b;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1, 1'b0);
    run_div(1'b0, 32'd5, 32'd0, 64'd0, 1, 1'b0);

    // Annul at E10: nothing may surface afterwards.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    ready_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ready_o) ready_seen++;
    end
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0, 1'b0);

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 5, 1'b1);

    // Reset at E15 of a division abandons it.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("midop_rst_ready", 64'(bus.ready_o), 64'd0);
    check("midop_rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 1'b0);

    // Reset while a finished result is held must clear it.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd8;
    bus.start_i      = 1'b1;
    exp_q.push_back({32'd2, 32'd6});
    repeat (36) @(negedge clk);
    check("end_before_rst_ready", 64'(bus.ready_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("end_rst_ready", 64'(bus.ready_o), 64'd0);
    check("end_rst_result", bus.result_o, 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if (i == 0) a = 32'h8000_0000;
      run_div(sgn, a, b, ref_div(sgn, a, b), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
